// File: rtl/tank_frame_sched.sv
// tank_frame_sched: once per video frame, updates every tank slot's heading and
// position, then grants the shared bullet launcher to one shooting tank by
// round-robin arbitration. All outputs are registered.
//
// Ports:
//   clk_25m      pixel clock
//   rst_n        asynchronous active-low reset
//   frame_start  one-cycle pulse at the start of vertical blank
//   dir_req      per-slot one-hot direction request, slot k at [4k+3:4k]
//                (1000 up, 0100 down, 0010 left, 0001 right)
//   shoot_req    per-slot fire request
//   tank_exist   per-slot alive flag
//   tank_x       packed x, slot k at [10k+9:10k]
//   tank_y       packed y, slot k at [10k+9:10k]
//   tank_dir     packed heading, slot k at [2k+1:2k] (0 up, 1 down, 2 left, 3 right)
//   fire_valid   launcher request
//   fire_id      granted slot
//   fire_ready   launcher accepts
//   busy         scheduler not idle
//   overrun      one-cycle pulse when frame_start arrives while busy
module tank_frame_sched #(
    parameter int unsigned NUM_TANKS = 5,
    parameter int unsigned X_MIN     = 3,
    parameter int unsigned X_MAX     = 609,
    parameter int unsigned Y_MIN     = 1,
    parameter int unsigned Y_MAX     = 449,
    parameter int unsigned STEP      = 1,
    parameter int unsigned SPAWN_DX  = 150
) (
    input  logic                      clk_25m,
    input  logic                      rst_n,
    input  logic                      frame_start,
    input  logic [4*NUM_TANKS-1:0]    dir_req,
    input  logic [NUM_TANKS-1:0]      shoot_req,
    input  logic [NUM_TANKS-1:0]      tank_exist,
    output logic [10*NUM_TANKS-1:0]   tank_x,
    output logic [10*NUM_TANKS-1:0]   tank_y,
    output logic [2*NUM_TANKS-1:0]    tank_dir,
    output logic                      fire_valid,
    output logic [2:0]                fire_id,
    input  logic                      fire_ready,
    output logic                      busy,
    output logic                      overrun
);

    typedef enum logic [2:0] {StIdle, StCapture, StMove, StArb, StFire} state_e;

    // 11-bit working copies so the +/- STEP bound tests never wrap.
    localparam logic [10:0] XMin    = 11'(X_MIN);
    localparam logic [10:0] XMax    = 11'(X_MAX);
    localparam logic [10:0] YMin    = 11'(Y_MIN);
    localparam logic [10:0] YMax    = 11'(Y_MAX);
    localparam logic [10:0] Step    = 11'(STEP);
    localparam logic [2:0]  LastIdx = 3'(NUM_TANKS - 1);

    state_e                 state;
    logic [2:0]             idx;
    logic [4*NUM_TANKS-1:0] dir_snap;
    logic [NUM_TANKS-1:0]   shoot_snap;
    logic [NUM_TANKS-1:0]   exist_snap;
    logic [9:0]             pos_x   [NUM_TANKS];
    logic [9:0]             pos_y   [NUM_TANKS];
    logic [1:0]             heading [NUM_TANKS];
    logic [2:0]             last_grant;

    // Next value for the slot currently addressed by idx.
    logic [3:0]  cur_req;
    logic [10:0] cur_x;
    logic [10:0] cur_y;
    logic [9:0]  nxt_x;
    logic [9:0]  nxt_y;
    logic [1:0]  nxt_dir;

    always_comb begin
        cur_req = dir_snap[4*idx +: 4];
        cur_x   = {1'b0, pos_x[idx]};
        cur_y   = {1'b0, pos_y[idx]};
        nxt_x   = pos_x[idx];
        nxt_y   = pos_y[idx];
        nxt_dir = heading[idx];
        if (exist_snap[idx]) begin
            // Anything other than exactly one bit set leaves the slot untouched.
            case (cur_req)
                4'b1000: begin
                    nxt_dir = 2'd0;
                    nxt_y   = (cur_y >= YMin + Step) ? 10'(cur_y - Step) : 10'(YMin);
                end
                4'b0100: begin
                    nxt_dir = 2'd1;
                    nxt_y   = (cur_y + Step <= YMax) ? 10'(cur_y + Step) : 10'(YMax);
                end
                4'b0010: begin
                    nxt_dir = 2'd2;
                    nxt_x   = (cur_x >= XMin + Step) ? 10'(cur_x - Step) : 10'(XMin);
                end
                4'b0001: begin
                    nxt_dir = 2'd3;
                    nxt_x   = (cur_x + Step <= XMax) ? 10'(cur_x + Step) : 10'(XMax);
                end
                default: ;
            endcase
        end
    end

    // Round-robin: first candidate strictly after last_grant, wrapping.
    logic [NUM_TANKS-1:0] cand;
    logic [2:0]           cand_slot;
    logic [2:0]           grant;
    logic                 found;

    always_comb begin
        cand      = shoot_snap & exist_snap;
        cand_slot = '0;
        grant     = last_grant;
        found     = 1'b0;
        for (int unsigned i = 1; i <= NUM_TANKS; i++) begin
            cand_slot = 3'((32'(last_grant) + i) % NUM_TANKS);
            if (!found && cand[cand_slot]) begin
                grant = cand_slot;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            idx        <= '0;
            dir_snap   <= '0;
            shoot_snap <= '0;
            exist_snap <= '0;
            last_grant <= LastIdx;
            fire_valid <= 1'b0;
            fire_id    <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            for (int k = 0; k < NUM_TANKS; k++) begin
                pos_x[k]   <= 10'(X_MIN + k * SPAWN_DX);
                pos_y[k]   <= 10'(Y_MIN);
                heading[k] <= 2'd1;
            end
        end else begin
            // A frame arriving mid-schedule is dropped, only flagged.
            overrun <= frame_start && (state != StIdle);
            case (state)
                StIdle: begin
                    if (frame_start) begin
                        state <= StCapture;
                        busy  <= 1'b1;
                    end
                end
                StCapture: begin
                    dir_snap   <= dir_req;
                    shoot_snap <= shoot_req;
                    exist_snap <= tank_exist;
                    idx        <= '0;
                    state      <= StMove;
                end
                StMove: begin
                    pos_x[idx]   <= nxt_x;
                    pos_y[idx]   <= nxt_y;
                    heading[idx] <= nxt_dir;
                    if (idx == LastIdx) begin
                        state <= StArb;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                StArb: begin
                    if (|cand) begin
                        fire_id    <= grant;
                        fire_valid <= 1'b1;
                        state      <= StFire;
                    end else begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end
                StFire: begin
                    // No timeout: the grant is held until the launcher takes it.
                    if (fire_ready) begin
                        last_grant <= fire_id;
                        fire_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        tank_x   = '0;
        tank_y   = '0;
        tank_dir = '0;
        for (int k = 0; k < NUM_TANKS; k++) begin
            tank_x[10*k +: 10]  = pos_x[k];
            tank_y[10*k +: 10]  = pos_y[k];
            tank_dir[2*k +: 2]  = heading[k];
        end
    end

endmodule

// File: doc/tank_frame_sched.md
# tank_frame_sched

Per-frame scheduler for the tank game. Once per video frame it sequences the state update of all tank slots (direction, position, field clamping), then grants the single shared bullet launcher to one shooting tank by round-robin arbitration. It sits between the input/AI direction sources and the VGA renderer. The packed position and direction buses feed the pixel compositor, and the fire handshake feeds the bullet engine. All updates finish inside vertical blanking, so the renderer never sees a mid-frame change.

## Interface
Parameters:
- NUM_TANKS, 5, number of tank slots (max 8).
- X_MIN, 3, leftmost legal tank x.
- X_MAX, 609, rightmost legal tank x (639-29-1).
- Y_MIN, 1, topmost legal tank y.
- Y_MAX, 449, bottom legal tank y (479-29-1).
- STEP, 1, pixels moved per frame.
- SPAWN_DX, 150, reset x spacing between slots.

Ports:
- clk_25m  in  1  pixel clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- frame_start  in  1  single-cycle pulse once per frame, issued by the timing generator at the start of vertical blank.
- dir_req  in  4*NUM_TANKS  per-slot direction request; slot k uses [4k+3:4k]; 1000=up, 0100=down, 0010=left, 0001=right.
- shoot_req  in  NUM_TANKS  per-slot fire request.
- tank_exist  in  NUM_TANKS  slot alive.
- tank_x  out  10*NUM_TANKS  packed x, slot k at [10k+9:10k].
- tank_y  out  10*NUM_TANKS  packed y.
- tank_dir  out  2*NUM_TANKS  packed heading; 0=up, 1=down, 2=left, 3=right.
- fire_valid  out  1  launcher request.
- fire_id  out  3  granted slot.
- fire_ready  in  1  launcher accepts.
- busy  out  1  scheduler not IDLE.
- overrun  out  1  one-cycle pulse when frame_start arrives while busy.

## Operation
- States: IDLE, CAPTURE, MOVE, ARB, FIRE.
- IDLE: frame_start=1 -> CAPTURE.
- CAPTURE: snapshot dir_req, shoot_req and tank_exist into internal registers, idx=0 -> MOVE.
  - Inputs are ignored outside CAPTURE.
- MOVE: processes slot idx, one slot per cycle, idx 0..NUM_TANKS-1. Last slot -> ARB.
- Per-slot update:
  - Slot not existing, or request not exactly one-hot: x, y and dir unchanged.
  - Otherwise dir takes the decoded heading and the position moves STEP in that direction with saturation.
  - Up: y = (y >= Y_MIN+STEP) ? y-STEP : Y_MIN. Down: y = (y+STEP <= Y_MAX) ? y+STEP : Y_MAX. Left and right apply the same rule to x against X_MIN and X_MAX.
  - Arithmetic is 11-bit internally, so nothing wraps.
  - A slot already at the bound keeps its position but still updates dir.
- ARB: candidates = shoot_snap & exist_snap.
  - None: go to IDLE; pointer unchanged.
  - Otherwise grant the first candidate after last_grant, searching cyclically. Register fire_id=grant and fire_valid=1, then go to FIRE.
- FIRE: hold fire_valid and a stable fire_id until fire_valid & fire_ready. On that cycle, set last_grant=grant, drop fire_valid, go to IDLE.
  - There is no timeout; the request persists across frames.
- frame_start in any state other than IDLE: ignored, overrun pulses for 1 cycle. No frame is queued.
- Reset values:
  - tank_x slot k = X_MIN + k*SPAWN_DX; tank_y = Y_MIN; tank_dir = 1 (down).
  - last_grant = NUM_TANKS-1, so slot 0 has first priority.
  - fire_valid=0, fire_id=0, busy=0, overrun=0, state IDLE.
- Reset asserted mid-operation aborts immediately to the reset values above. A pending fire is dropped.

## Timing
- frame_start sampled high at edge T: state CAPTURE after edge T, and busy goes high after edge T.
- Edge T+1: snapshot taken.
- Edges T+2 .. T+1+NUM_TANKS: slot 0..N-1 outputs update. Slot k's new value is visible after edge T+2+k.
- Edge T+2+NUM_TANKS (ARB): fire_valid high after this edge; or, with no candidates, busy low after it.
- Fire handshake completes on the first edge with fire_ready=1 while in FIRE. fire_valid and busy are low after that edge.
- With NUM_TANKS=5 and fire_ready tied high, the worst case is 9 cycles, far inside the 10-line (8000-cycle) blanking window.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: after rst_n release, tank_x = {3,153,303,453,603}, tank_y all 1, tank_dir all 1, fire_valid=0, busy=0.
- Slot 0 dir_req=0001 for 3 frames -> x0=6 and dir0=3. In the same frames, slot 1 dir_req=1000 -> y1 stays 1 and dir1 becomes 0.
- Slot 4 right for 10 frames -> x4 reaches 609 after 6 frames and stays 609. dir_req=1100, or tank_exist[2]=0 -> slot 2 unchanged.
- shoot_req=10101 every frame, fire_ready=1 -> fire_id sequence 0,2,4,0,2. fire_valid is high for exactly 1 cycle per frame, at T+7.
- Backpressure: fire_ready=0 across 2 frame_starts -> fire_valid held and fire_id stable, overrun pulses on the second frame_start, positions frozen. fire_ready=1 then completes the grant.
- rst_n asserted during MOVE at slot 2 -> all outputs return to reset values immediately. The next frame_start processes normally.
